// File: rtl/motor_plant_model.sv
// Four-channel motor plant: each channel integrates scaled drive with one cycle of delay,
// clamps to 0..RPM_MAX without windup, and latches an overload after a sustained ceiling hold.
module motor_plant_model #(
    parameter int unsigned SHIFT        = 3,
    parameter logic [15:0] RPM_MAX      = 16'h157C,
    parameter int unsigned STALL_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr_fault,
    input  logic [3:0][15:0] mot_set,
    output logic [3:0][15:0] rpm_sense,
    output logic [3:0]       sat_hi,
    output logic [3:0]       sat_lo,
    output logic [3:0]       overload
);

    localparam logic [15:0] STALL_MAX = 16'(STALL_CYCLES);

    // Sum at 18 bits so neither a full-scale negative nor positive step can wrap before the clamp.
    function automatic logic [15:0] clamp_sum(input logic [15:0] acc, input logic [15:0] xd);
        logic signed [17:0] sum;
        sum = $signed({2'b00, acc}) + $signed({{2{xd[15]}}, xd});
        if (sum < 18'sd0) begin
            clamp_sum = 16'h0000;
        end else if (sum > $signed({2'b00, RPM_MAX})) begin
            clamp_sum = RPM_MAX;
        end else begin
            clamp_sum = sum[15:0];
        end
    endfunction

    logic [3:0][15:0] r_xd;
    logic [3:0][15:0] r_acc;
    logic [3:0][15:0] r_stall;
    logic [3:0]       r_overload;

    logic [3:0][15:0] w_xd_nxt;
    logic [3:0][15:0] w_acc_nxt;
    logic [3:0][15:0] w_stall_nxt;
    logic [3:0]       w_ovl_set;

    // Next-state arithmetic for every channel, independent of enable.
    always_comb begin
        w_xd_nxt    = '0;
        w_acc_nxt   = '0;
        w_stall_nxt = '0;
        w_ovl_set   = '0;
        for (int i = 0; i < 4; i++) begin
            w_xd_nxt[i]  = 16'($signed(mot_set[i]) >>> SHIFT);
            w_acc_nxt[i] = clamp_sum(r_acc[i], r_xd[i]);
            if (w_acc_nxt[i] == RPM_MAX) begin
                if (r_stall[i] == STALL_MAX) begin
                    w_stall_nxt[i] = r_stall[i];
                end else begin
                    w_stall_nxt[i] = r_stall[i] + 16'd1;
                end
            end else begin
                w_stall_nxt[i] = 16'd0;
            end
            w_ovl_set[i] = (w_stall_nxt[i] == STALL_MAX);
        end
    end

    // Drive pipeline and accumulator: frozen while disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_xd  <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_xd  <= w_xd_nxt;
            r_acc <= w_acc_nxt;
        end else begin
            r_xd  <= r_xd;
            r_acc <= r_acc;
        end
    end

    // Stall counters and sticky overload; a fault clear wins over a same-edge threshold hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall    <= '0;
            r_overload <= 4'b0000;
        end else if (clr_fault) begin
            r_stall    <= '0;
            r_overload <= 4'b0000;
        end else if (en) begin
            r_stall    <= w_stall_nxt;
            r_overload <= r_overload | w_ovl_set;
        end else begin
            r_stall    <= r_stall;
            r_overload <= r_overload;
        end
    end

    // Saturation flags are direct compares on the accumulator registers.
    always_comb begin
        rpm_sense = r_acc;
        overload  = r_overload;
        sat_hi    = 4'b0000;
        sat_lo    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sat_hi[i] = (r_acc[i] == RPM_MAX);
            sat_lo[i] = (r_acc[i] == 16'h0000);
        end
    end

endmodule

// File: tb/tb_motor_plant_model.sv
// Directed bench for motor_plant_model: ramp, reverse drain, overload timing,
// fault-clear priority, enable freeze and asynchronous reset.
module tb_motor_plant_model;

    logic             clk;
    logic             resetn;
    logic             en;
    logic             clr_fault;
    logic [3:0][15:0] mot_set;
    logic [3:0][15:0] rpm_sense;
    logic [3:0]       sat_hi;
    logic [3:0]       sat_lo;
    logic [3:0]       overload;

    int checks = 0;
    int errors = 0;

    motor_plant_model #(
        .SHIFT        (3),
        .RPM_MAX      (16'h157C),
        .STALL_CYCLES (64)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .clr_fault (clr_fault),
        .mot_set   (mot_set),
        .rpm_sense (rpm_sense),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .overload  (overload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, leaving the bench on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        en        = 1'b0;
        clr_fault = 1'b0;
        mot_set   = '0;
        resetn    = 1'b0;
        @(negedge clk);
        resetn    = 1'b1;
    endtask

    // Pulse reset between edges and check that outputs clear before any clock edge.
    task automatic reset_pulse(input string tag);
        #2 resetn = 1'b0;
        #1;
        check({tag, "_rpm"},  rpm_sense, 64'h0);
        check({tag, "_lo"},   {60'h0, sat_lo}, 64'hF);
        check({tag, "_hi"},   {60'h0, sat_hi}, 64'h0);
        check({tag, "_ovl"},  {60'h0, overload}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        en        = 1'b0;
        clr_fault = 1'b0;
        mot_set   = '0;

        // Reset state and ramp to ceiling on channel 0
        do_reset();
        check("rst_rpm", rpm_sense, 64'h0);
        check("rst_lo",  {60'h0, sat_lo}, 64'hF);
        check("rst_hi",  {60'h0, sat_hi}, 64'h0);
        check("rst_ovl", {60'h0, overload}, 64'h0);
        en = 1'b1;
        mot_set[0] = 16'h0800;
        tick(1);
        check("ramp_e1", rpm_sense, 64'h0);
        tick(1);
        check("ramp_e2", rpm_sense, 64'h0100);
        tick(20);
        check("ramp_e22", rpm_sense, 64'h1500);
        tick(1);
        check("ramp_e23", rpm_sense, 64'h157C);
        check("ramp_hi",  {60'h0, sat_hi}, 64'h1);
        check("ramp_lo",  {60'h0, sat_lo}, 64'hE);
        tick(1);
        check("ramp_e24", rpm_sense, 64'h157C);

        // Reverse drive drains channel 1 from 0x300 to 0 without wrapping
        do_reset();
        en = 1'b1;
        mot_set[1] = 16'h0800;
        tick(3);
        mot_set[1] = 16'hF800;
        tick(1);
        check("rev_300", rpm_sense, {16'h0, 16'h0, 16'h0300, 16'h0});
        tick(1);
        check("rev_200", rpm_sense, {16'h0, 16'h0, 16'h0200, 16'h0});
        tick(1);
        check("rev_100", rpm_sense, {16'h0, 16'h0, 16'h0100, 16'h0});
        tick(1);
        check("rev_000", rpm_sense, 64'h0);
        tick(1);
        check("rev_hold", rpm_sense, 64'h0);
        check("rev_lo",   {60'h0, sat_lo}, 64'hF);
        mot_set[1] = 16'h8000;
        tick(2);
        check("rev_min", rpm_sense, 64'h0);
        check("rev_min_lo", {60'h0, sat_lo}, 64'hF);

        // Full-scale positive drive on channel 2 and overload timing
        do_reset();
        en = 1'b1;
        mot_set[2] = 16'h7FFF;
        tick(2);
        check("max_e2", rpm_sense, {16'h0, 16'h0FFF, 16'h0, 16'h0});
        tick(1);
        check("max_e3", rpm_sense, {16'h0, 16'h157C, 16'h0, 16'h0});
        tick(62);
        check("ovl_e65", {60'h0, overload}, 64'h0);
        tick(1);
        check("ovl_e66", {60'h0, overload}, 64'h4);

        // Asynchronous reset while saturated with overload set
        reset_pulse("arst_ovl");

        // A one-edge dip below the ceiling restarts the stall count
        tick(3);
        check("dip_e3", rpm_sense, {16'h0, 16'h157C, 16'h0, 16'h0});
        tick(60);
        mot_set[2] = 16'hFFF8;
        tick(1);
        check("dip_e64", rpm_sense, {16'h0, 16'h157C, 16'h0, 16'h0});
        mot_set[2] = 16'h7FFF;
        tick(1);
        check("dip_e65", rpm_sense, {16'h0, 16'h157B, 16'h0, 16'h0});
        check("dip_hi",  {60'h0, sat_hi}, 64'h0);
        tick(1);
        check("dip_e66", rpm_sense, {16'h0, 16'h157C, 16'h0, 16'h0});
        tick(62);
        check("dip_e128", {60'h0, overload}, 64'h0);
        tick(1);
        check("dip_e129", {60'h0, overload}, 64'h4);

        // Fault clear on the threshold edge wins
        do_reset();
        en = 1'b1;
        mot_set[2] = 16'h7FFF;
        tick(65);
        check("clr_e65", {60'h0, overload}, 64'h0);
        clr_fault = 1'b1;
        tick(1);
        check("clr_e66", {60'h0, overload}, 64'h0);
        clr_fault = 1'b0;
        tick(63);
        check("clr_e129", {60'h0, overload}, 64'h0);
        tick(1);
        check("clr_e130", {60'h0, overload}, 64'h4);
        en = 1'b0;
        clr_fault = 1'b1;
        tick(1);
        check("clr_dis_ovl", {60'h0, overload}, 64'h0);
        check("clr_dis_rpm", rpm_sense, {16'h0, 16'h157C, 16'h0, 16'h0});
        clr_fault = 1'b0;
        en = 1'b1;
        tick(1);
        check("clr_restart", {60'h0, overload}, 64'h0);

        // Enable freeze mid-ramp on channel 3, then held xd applied first
        do_reset();
        en = 1'b1;
        mot_set[3] = 16'h0800;
        tick(8);
        check("frz_e8", rpm_sense, {16'h0700, 16'h0, 16'h0, 16'h0});
        en = 1'b0;
        mot_set[3] = 16'h1000;
        tick(10);
        check("frz_hold", rpm_sense, {16'h0700, 16'h0, 16'h0, 16'h0});
        en = 1'b1;
        tick(1);
        check("frz_re1", rpm_sense, {16'h0800, 16'h0, 16'h0, 16'h0});
        tick(1);
        check("frz_re2", rpm_sense, {16'h0A00, 16'h0, 16'h0, 16'h0});

        // Asynchronous reset mid-ramp and restart latency
        reset_pulse("arst_ramp");
        tick(1);
        check("post_rst_e1", rpm_sense, 64'h0);
        tick(1);
        check("post_rst_e2", rpm_sense, {16'h0200, 16'h0, 16'h0, 16'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
